// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-requester RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_VID = 1;
  localparam int REQ_IO  = 2;

  localparam int RAM_DEPTH_DEF = 48;

  // Priority pointer after a grant: one past the winner, wrapping modulo 3.
  function automatic logic [1:0] ptr_after(input logic [2:0] win);
    logic [1:0] p;
    p = 2'd0;
    if (win[REQ_CPU]) p = 2'd1;
    else if (win[REQ_VID]) p = 2'd2;
    return p;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: first set req at or above ptr, wrapping.
module rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic       vld
);

  always_comb begin
    win = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd2: begin
        if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
    vld = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving three requesters one-at-a-time access to a single RAM port.
// Writes take 2 cycles (IDLE, ACCESS); reads take 3 (IDLE, ACCESS, RESP).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 16,
  parameter int RAM_DEPTH     = RAM_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic [2:0]               we,
  input  logic [RAM_ADDR_BITS-1:0] adr0,
  input  logic [RAM_ADDR_BITS-1:0] adr1,
  input  logic [RAM_ADDR_BITS-1:0] adr2,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [WIDTH-1:0]         wdata2,
  output logic [2:0]               gnt,
  output logic [2:0]               rvalid,
  output logic [WIDTH-1:0]         rdata,
  output logic                     err,
  output logic                     mem_en,
  output logic                     mem_memwrite,
  output logic                     mem_memread,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_writedata,
  input  logic [WIDTH-1:0]         mem_memdata
);

  localparam logic [RAM_ADDR_BITS:0] DEPTH_L = (RAM_ADDR_BITS+1)'(RAM_DEPTH);

  state_t                   state;
  logic [1:0]               ptr;
  logic [2:0]               win;
  logic                     win_vld;
  logic [2:0]               l_win;
  logic                     l_we;
  logic                     l_ok;
  logic                     sel_we;
  logic                     sel_ok;
  logic [RAM_ADDR_BITS-1:0] sel_adr;
  logic [WIDTH-1:0]         sel_wdata;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .vld (win_vld)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_adr   = '0;
    sel_wdata = '0;
    if (win[REQ_CPU]) begin
      sel_we = we[REQ_CPU]; sel_adr = adr0; sel_wdata = wdata0;
    end else if (win[REQ_VID]) begin
      sel_we = we[REQ_VID]; sel_adr = adr1; sel_wdata = wdata1;
    end else if (win[REQ_IO]) begin
      sel_we = we[REQ_IO];  sel_adr = adr2; sel_wdata = wdata2;
    end
    sel_ok = ({1'b0, sel_adr} < DEPTH_L);
  end

  // RAM data is registered on the ACCESS edge, so it is valid throughout RESP.
  assign rdata = (state == ST_RESP && l_ok) ? mem_memdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      ptr           <= 2'd0;
      gnt           <= 3'b000;
      rvalid        <= 3'b000;
      err           <= 1'b0;
      mem_en        <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_memread   <= 1'b0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      l_win         <= 3'b000;
      l_we          <= 1'b0;
      l_ok          <= 1'b0;
    end else begin
      gnt           <= 3'b000;
      rvalid        <= 3'b000;
      err           <= 1'b0;
      mem_en        <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_memread   <= 1'b0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state         <= ST_ACCESS;
            gnt           <= win;
            mem_adr       <= sel_adr;
            mem_writedata <= sel_wdata;
            mem_en        <= sel_ok;
            mem_memwrite  <= sel_ok & sel_we;
            mem_memread   <= sel_ok & ~sel_we;
            err           <= ~sel_ok;
            l_win         <= win;
            l_we          <= sel_we;
            l_ok          <= sel_ok;
            ptr           <= ptr_after(win);
          end
        end
        ST_ACCESS: begin
          if (l_we) begin
            state <= ST_IDLE;
            l_win <= 3'b000;
            l_we  <= 1'b0;
            l_ok  <= 1'b0;
          end else begin
            state  <= ST_RESP;
            rvalid <= l_win;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          l_win <= 3'b000;
          l_we  <= 1'b0;
          l_ok  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected accesses/reads,
// a negedge monitor pops and compares whenever gnt or rvalid is presented.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req, we;
  logic [15:0] adr0, adr1, adr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        err, mem_en, mem_memwrite, mem_memread;
  logic [15:0] mem_adr, mem_writedata, mem_memdata;

  mem_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(16), .RAM_DEPTH(48)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_adr(mem_adr), .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with registered read data
  logic [15:0] ram [64];
  always @(posedge clk) begin
    if (mem_en && mem_memwrite) ram[mem_adr[5:0]] <= mem_writedata;
    if (mem_en && mem_memread) mem_memdata <= ram[mem_adr[5:0]];
  end

  typedef struct {
    logic [2:0]  gnt;
    logic        en, wr, rd, err;
    logic [15:0] adr, wd;
  } gexp_t;
  typedef struct {
    logic [2:0]  rv;
    logic [15:0] dat;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic [2:0] g, input logic en, input logic wr, input logic rd,
                        input logic e, input logic [15:0] a, input logic [15:0] d);
    gexp_t x;
    x.gnt = g; x.en = en; x.wr = wr; x.rd = rd; x.err = e; x.adr = a; x.wd = d;
    gq.push_back(x);
  endtask

  task automatic push_r(input logic [2:0] v, input logic [15:0] d);
    rexp_t x;
    x.rv = v; x.dat = d;
    rq.push_back(x);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (gnt !== 3'b000) begin
      chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
      last_gnt_cyc = cyc;
      if (gq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_gnt: got %b expected none", gnt);
      end else begin
        ge = gq.pop_front();
        chk("access", {gnt, mem_en, mem_memwrite, mem_memread, err, mem_adr, mem_writedata},
            {ge.gnt, ge.en, ge.wr, ge.rd, ge.err, ge.adr, ge.wd});
      end
    end else begin
      chk("idle_outputs", {mem_en, mem_memwrite, mem_memread, err, mem_adr, mem_writedata}, 64'd0);
    end
    if (rvalid !== 3'b000) begin
      chk("rvalid_latency", 64'(cyc - last_gnt_cyc), 64'd1);
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rvalid: got %b expected none", rvalid);
      end else begin
        re = rq.pop_front();
        chk("read", {rvalid, rdata}, {re.rv, re.dat});
      end
    end
  end

  // Hold the requests in mask until each is granted; waited = negedges to first grant.
  task automatic run_reqs(input logic [2:0] mask, output int waited);
    waited = 0;
    req = req | mask;
    for (int c = 1; c <= 50 && (req & mask) != 3'b000; c++) begin
      @(negedge clk);
      if (waited == 0 && (gnt & mask) != 3'b000) waited = c;
      we  = we & ~gnt;
      req = req & ~gnt;
    end
    if ((req & mask) != 3'b000) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: got req %b pending expected none", req & mask);
      req = req & ~mask;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ngnt;
    rst = 1'b0; req = 3'b000; we = 3'b000;
    adr0 = '0; adr1 = '0; adr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
    for (int i = 0; i < 64; i++) ram[i] = 16'hA000 + 16'(i);
    ram[6'h20] = 16'h1234;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt, rvalid, err, mem_en, mem_memwrite, mem_memread, mem_adr, mem_writedata, rdata}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // CPU write
    adr0 = 16'h0010; wdata0 = 16'hBEEF; we = 3'b001;
    push_g(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
    run_reqs(3'b001, w);
    chk("write_gnt_latency", 64'(w), 64'd1);
    repeat (3) @(negedge clk);
    chk("ram_write", {48'd0, ram[6'h10]}, 64'h0000_0000_0000_BEEF);

    // IO read
    adr2 = 16'h0020; wdata2 = 16'h0000; we = 3'b000;
    push_g(3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    push_r(3'b100, 16'h1234);
    run_reqs(3'b100, w);
    chk("read_gnt_latency", 64'(w), 64'd1);
    repeat (3) @(negedge clk);

    // All three reading continuously from reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    adr0 = 16'd1; adr1 = 16'd2; adr2 = 16'd3;
    wdata0 = '0; wdata1 = '0; wdata2 = '0; we = 3'b000;
    for (int k = 0; k < 2; k++) begin
      push_g(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0); push_r(3'b001, 16'hA001);
      push_g(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd0); push_r(3'b010, 16'hA002);
      push_g(3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 16'd0); push_r(3'b100, 16'hA003);
    end
    req = 3'b111;
    ngnt = 0;
    for (int c = 0; c < 40 && ngnt < 6; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) ngnt++;
    end
    req = 3'b000;
    chk("rr_grant_count", 64'(ngnt), 64'd6);
    repeat (3) @(negedge clk);

    // Out-of-range video write, then out-of-range CPU read
    adr1 = 16'h0030; wdata1 = 16'h5555; we = 3'b010;
    push_g(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h5555);
    run_reqs(3'b010, w);
    adr0 = 16'h0040; wdata0 = 16'h0000; we = 3'b000;
    push_g(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000);
    push_r(3'b001, 16'h0000);
    run_reqs(3'b001, w);
    repeat (3) @(negedge clk);
    chk("ram_oor_untouched", {48'd0, ram[6'h30]}, 64'h0000_0000_0000_A030);

    // Reset during ACCESS of a video read
    adr1 = 16'd4; wdata1 = 16'h0000; we = 3'b000;
    push_g(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 16'h0000);
    run_reqs(3'b010, w);
    #2 rst = 1'b0;
    #1 chk("reset_mid_access", {gnt, rvalid, err, mem_en, mem_memwrite, mem_memread, mem_adr, mem_writedata, rdata}, 64'd0);
    repeat (2) @(negedge clk);
    adr1 = 16'd5; adr2 = 16'd6;
    push_g(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 16'd0); push_r(3'b010, 16'hA005);
    push_g(3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 16'd6, 16'd0); push_r(3'b100, 16'hA006);
    rst = 1'b1;
    run_reqs(3'b110, w);
    chk("post_reset_gnt_latency", 64'(w), 64'd1);
    repeat (5) @(negedge clk);

    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("rvalid_queue_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of RAM words and requester data.
REQ-002 Parameter RAM_ADDR_BITS, default 16, address width.
REQ-003 Parameter RAM_DEPTH, default 48, number of implemented RAM words; addresses >= RAM_DEPTH are out of range.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low: low clears all state immediately.
REQ-006 req[2:0]  input  3  per-requester access request (0=CPU, 1=video, 2=IO/player input).
REQ-007 we[2:0]  input  3  per-requester write-enable, qualified by req.
REQ-008 adr0/adr1/adr2  input  RAM_ADDR_BITS each  per-requester address.
REQ-009 wdata0/wdata1/wdata2  input  WIDTH each  per-requester write data.
REQ-010 gnt[2:0]  output  3  one-hot grant pulse, one cycle.
REQ-011 rvalid[2:0]  output  3  one-hot read-data-valid pulse, one cycle.
REQ-012 rdata  output  WIDTH  read data shared by all requesters, meaningful only with rvalid.
REQ-013 err  output  1  one-cycle pulse on an out-of-range access.
REQ-014 mem_en, mem_memwrite, mem_memread  output  1 each  RAM port controls.
REQ-015 mem_adr  output  RAM_ADDR_BITS; mem_writedata  output  WIDTH  RAM port address and write data.
REQ-016 mem_memdata  input  WIDTH  RAM registered read data, valid the cycle after a read strobe.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
REQ-018 IDLE: req sampled only here; when any req bit is set, pick a winner by round-robin, latch its we/adr/wdata, and go to ACCESS on the next edge; with no req, remain in IDLE.
REQ-019 Round-robin: the priority pointer starts at 0; the winner is the first set req bit at or above the pointer, wrapping modulo 3; after each grant, pointer = winner+1 mod 3.
REQ-020 ACCESS lasts exactly one cycle: gnt[winner]=1; mem_adr and mem_writedata drive the latched values (registered outputs).
REQ-021 ACCESS, in-range write: mem_en=1, mem_memwrite=1, mem_memread=0; next state IDLE.
REQ-022 ACCESS, in-range read: mem_en=1, mem_memread=1, mem_memwrite=0; next state RESP.
REQ-023 ACCESS, out-of-range (adr >= RAM_DEPTH): mem_en=0 and err=1; a write goes to IDLE and is dropped; a read goes to RESP.
REQ-024 RESP lasts one cycle: rvalid[winner]=1; rdata = mem_memdata for in-range reads, 0 for out-of-range reads; next state IDLE.
REQ-025 Latency from req sampled in IDLE: gnt at cycle +1 and rvalid at cycle +2. Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-026 Requesters hold req/we/adr/wdata until their gnt. Deasserting req before gnt withdraws the request with no side effects. req held after gnt is treated as a new request.
REQ-027 All outputs other than rdata are zero outside the states stated above.
REQ-028 At most one gnt, rvalid and RAM strobe active per cycle; simultaneous requests never produce two accesses in the same cycle.
REQ-029 Fairness: a continuously asserted req is granted within 2 intervening grants.

Reset
REQ-030 rst low forces, immediately: state=IDLE, pointer=0, gnt=0, rvalid=0, err=0, mem_en/mem_memwrite/mem_memread=0, mem_adr=0, mem_writedata=0, rdata=0, latched request cleared.
REQ-031 Reset during ACCESS or RESP abandons the access: no strobe and no rvalid after rst rises; the first edge after release samples req in IDLE.

Structure
REQ-032 Shared package holds: the FSM state enum, requester index constants (REQ_CPU=0, REQ_VID=1, REQ_IO=2), and the RAM_DEPTH default 48.
REQ-033 One sub-module, rr_pick: combinational 3-way round-robin picker (req, pointer -> one-hot winner, valid).

Verification
REQ-034 Single CPU write: req=001, we=001, adr0=0x10, wdata0=0xBEEF -> gnt=001 next cycle with mem_en=1, mem_memwrite=1, mem_adr=0x10, mem_writedata=0xBEEF; FSM returns to IDLE.
REQ-035 IO read: req=100, adr2=0x20, RAM returns 0x1234 -> gnt=100 at +1, rvalid=100 and rdata=0x1234 at +2.
REQ-036 All three requesters reading continuously from reset -> grant order 0,1,2,0,1,2; never two gnt bits set at once.
REQ-037 Video write to adr1=0x30 (48) -> gnt=010 and err=1 in the same cycle, mem_en=0, RAM unchanged; then a read of adr=0x40 returns rvalid with rdata=0.
REQ-038 rst low during ACCESS of a read -> all outputs 0 immediately, no rvalid after release, pointer=0; after release, simultaneous req=110 grants requester 1 first.
